// File: rtl/somador_serial.sv
// somador_serial: bit-serial adder, R = A + B + TE over WIDTH bits.
// One full-adder cell and a carry flip-flop process one bit per clock.
// Operands enter through a start/ready handshake (inicio/pronto), and
// the {carry-out, sum} result is announced by a one-cycle valido pulse.
module somador_serial #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inicio,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             TE,
   output logic             pronto,
   output logic             valido,
   output logic [WIDTH:0]   R
);

   // Counter wide enough for 0..WIDTH-1, never narrower than one bit.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      SOMA   = 2'd1,
      FIM    = 2'd2
   } estado_t;

   estado_t          estado_q, estado_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   r_q, r_d;

   // Full-adder cell fed by the LSBs of the operand shift registers.
   logic             s_bit;
   logic             c_out;
   logic [WIDTH-1:0] sum_shift;

   assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
   assign c_out = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

   // Sum bits enter at the MSB and move down, so the first (LSB) result
   // bit reaches position 0 after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_sum_one
         assign sum_shift = s_bit;
      end else begin : g_sum_many
         assign sum_shift = {s_bit, sum_q[WIDTH-1:1]};
      end
   endgenerate

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= OCIOSO;
         a_q      <= '0;
         b_q      <= '0;
         sum_q    <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         r_q      <= '0;
      end else begin
         estado_q <= estado_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sum_q    <= sum_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         r_q      <= r_d;
      end
   end

   // Next-state and datapath update: latch on accept, one bit per SOMA edge.
   always_comb begin
      estado_d = estado_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      case (estado_q)
         OCIOSO: begin
            if (inicio) begin
               a_d      = A;
               b_d      = B;
               c_d      = TE;
               sum_d    = '0;
               cnt_d    = '0;
               estado_d = SOMA;
            end
         end
         SOMA: begin
            sum_d = sum_shift;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = c_out;
            if (cnt_q == CNT_LAST) begin
               // Last bit: publish the full result; counter stays put.
               r_d      = {c_out, sum_shift};
               estado_d = FIM;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FIM: begin
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   assign pronto = (estado_q == OCIOSO);
   assign valido = (estado_q == FIM);
   assign R      = r_q;

endmodule

// File: tb/tb_somador_serial.sv
// tb_somador_serial: directed checks on a WIDTH=2 instance and a randomized
// run on a WIDTH=8 instance, both compared against plain-arithmetic sums.
module tb_somador_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=2 instance
   logic       rst2, ini2, te2, pr2, va2;
   logic [1:0] a2, b2;
   logic [2:0] r2;

   // WIDTH=8 instance
   logic       rst8, ini8, te8, pr8, va8;
   logic [7:0] a8, b8;
   logic [8:0] r8;

   somador_serial #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst2), .inicio(ini2), .A(a2), .B(b2), .TE(te2),
      .pronto(pr2), .valido(va2), .R(r2)
   );

   somador_serial #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .inicio(ini8), .A(a8), .B(b8), .TE(te8),
      .pronto(pr8), .valido(va8), .R(r8)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_r2;
   logic [31:0] exp_r8;
   logic [31:0] rnd;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One WIDTH=2 operation, entered at a negedge with the DUT idle.
   // Operands and inicio are scrambled after accept to show they are ignored.
   task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic te);
      logic [31:0] exp;
      int          n;
      bit          found;
      exp   = 32'(a) + 32'(b) + 32'(te);
      a2    = a; b2 = b; te2 = te; ini2 = 1'b1;
      n     = 0;
      found = 1'b0;
      while (!found && n < 20) begin
         @(negedge clk);
         n++;
         rnd  = $urandom;
         ini2 = rnd[0]; a2 = rnd[2:1]; b2 = rnd[4:3]; te2 = rnd[5];
         if (va2) found = 1'b1;
         else begin
            check_val("w2_hold", 32'(r2), exp_r2);
            check_val("w2_busy", 32'(pr2), 32'd0);
         end
      end
      check_val("w2_latency", 32'(n), 32'd3);
      check_val("w2_result", 32'(r2), exp);
      exp_r2 = exp;
      @(negedge clk);
      ini2 = 1'b0;
      check_val("w2_pulse", 32'(va2), 32'd0);
      check_val("w2_pronto", 32'(pr2), 32'd1);
      check_val("w2_after", 32'(r2), exp_r2);
      $display("w2 op A=%0d B=%0d TE=%0d -> R=%0d (exp %0d) latency %0d", a, b, te, r2, exp, n);
   endtask

   // One WIDTH=8 operation, same structure, expected latency WIDTH+1 = 9.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic te, input bit verbose);
      logic [31:0] exp;
      int          n;
      bit          found;
      exp   = 32'(a) + 32'(b) + 32'(te);
      a8    = a; b8 = b; te8 = te; ini8 = 1'b1;
      n     = 0;
      found = 1'b0;
      while (!found && n < 30) begin
         @(negedge clk);
         n++;
         rnd  = $urandom;
         ini8 = rnd[0]; a8 = rnd[8:1]; b8 = rnd[16:9]; te8 = rnd[17];
         if (va8) found = 1'b1;
         else check_val("w8_hold", 32'(r8), exp_r8);
      end
      check_val("w8_latency", 32'(n), 32'd9);
      check_val("w8_result", 32'(r8), exp);
      exp_r8 = exp;
      @(negedge clk);
      ini8 = 1'b0;
      check_val("w8_pulse", 32'(va8), 32'd0);
      check_val("w8_pronto", 32'(pr8), 32'd1);
      if (verbose)
         $display("w8 op A=%0d B=%0d TE=%0d -> R=%0d (exp %0d) latency %0d", a, b, te, r8, exp, n);
   endtask

   initial begin
      rst2 = 1'b1; ini2 = 1'b0; a2 = '0; b2 = '0; te2 = 1'b0;
      rst8 = 1'b1; ini8 = 1'b0; a8 = '0; b8 = '0; te8 = 1'b0;
      exp_r2 = 32'd0;
      exp_r8 = 32'd0;

      // Reset held for two edges
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_pronto", 32'(pr2), 32'd1);
      check_val("rst_valido", 32'(va2), 32'd0);
      check_val("rst_r", 32'(r2), 32'd0);
      check_val("rst8_pronto", 32'(pr8), 32'd1);
      check_val("rst8_r", 32'(r8), 32'd0);
      $display("reset: pronto=%0d valido=%0d R=%0d", pr2, va2, r2);
      rst2 = 1'b0;
      rst8 = 1'b0;
      @(negedge clk);

      // Directed WIDTH=2 operations, including R holding across the next op
      run2(2'd3, 2'd3, 1'b1);
      run2(2'd2, 2'd1, 1'b0);
      run2(2'd0, 2'd0, 1'b0);

      // inicio held high: one result every 4 cycles, operands scrambled while busy
      a2 = 2'd1; b2 = 2'd1; te2 = 1'b0; ini2 = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         check_val("cont_valido", 32'(va2), ((n % 4) == 3) ? 32'd1 : 32'd0);
         check_val("cont_pronto", 32'(pr2), ((n % 4) == 0) ? 32'd1 : 32'd0);
         if ((n % 4) == 3) begin
            check_val("cont_r", 32'(r2), 32'd2);
            $display("cont result at cycle %0d R=%0d", n, r2);
         end
         if ((n % 4) == 0) begin
            a2 = 2'd1; b2 = 2'd1; te2 = 1'b0;
         end else begin
            rnd = $urandom;
            a2 = rnd[1:0]; b2 = rnd[3:2]; te2 = rnd[4];
         end
      end
      ini2   = 1'b0;
      exp_r2 = 32'd2;
      @(negedge clk);

      // Reset one edge into SOMA aborts the operation
      a2 = 2'd3; b2 = 2'd2; te2 = 1'b1; ini2 = 1'b1;
      @(negedge clk);
      ini2 = 1'b0;
      rst2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      check_val("abort_pronto", 32'(pr2), 32'd1);
      check_val("abort_valido", 32'(va2), 32'd0);
      check_val("abort_r", 32'(r2), 32'd0);
      exp_r2 = 32'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_val("abort_novalid", 32'(va2), 32'd0);
      end
      $display("abort: pronto=%0d valido=%0d R=%0d", pr2, va2, r2);
      run2(2'd1, 2'd2, 1'b1);

      // WIDTH=8: corner case then randomized operations
      run8(8'd255, 8'd255, 1'b1, 1'b1);
      run8(8'd0, 8'd0, 1'b0, 1'b1);
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] v;
         v = $urandom;
         run8(v[7:0], v[15:8], v[16], (i % 100) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
